// File: rtl/mac_dot_sequencer.sv
// mac_dot_sequencer
// Runs one shared multiplier through an N-element dot product. On each RUN
// cycle it reads one activation/weight pair from two 1-cycle-latency RAMs. It
// passes the read data straight to the multiplier, adds the products into a
// signed accumulator, and presents the sum on a valid/ready handshake.
//
// Build option: MAC_SEQ_RELU_EN
//    When defined, a negative result is clamped to zero at the output register.
//    The internal accumulator is not clamped.
//
// Ports
//    ap_clk, ap_rst_n     clock, asynchronous active-low reset
//    start, len           request and element count (sampled only in IDLE)
//    busy                 high whenever the sequencer is not IDLE
//    a_addr/a_ce/a_q      activation RAM read port
//    b_addr/b_ce/b_q      weight RAM read port (address/enable mirror a_*)
//    mul_a/mul_b/mul_p    external multiplier operands and product
//    acc_out/acc_valid/acc_ready  result handshake
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | waiting for start; RAM reads disabled
// S_RUN   | one RAM read per cycle; accumulating the previous read
// S_DRAIN | no read issued; accumulating the last element
// S_OUT   | result presented; held until acc_ready

module mac_dot_sequencer #(
   parameter int A_WIDTH    = 13,
   parameter int B_WIDTH    = 10,
   parameter int P_WIDTH    = 23,
   parameter int ACC_WIDTH  = 32,
   parameter int ADDR_WIDTH = 10
) (
   input  logic                  ap_clk,
   input  logic                  ap_rst_n,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] len,
   output logic                  busy,
   output logic [ADDR_WIDTH-1:0] a_addr,
   output logic                  a_ce,
   input  logic [A_WIDTH-1:0]    a_q,
   output logic [ADDR_WIDTH-1:0] b_addr,
   output logic                  b_ce,
   input  logic [B_WIDTH-1:0]    b_q,
   output logic [A_WIDTH-1:0]    mul_a,
   output logic [B_WIDTH-1:0]    mul_b,
   input  logic [P_WIDTH-1:0]    mul_p,
   output logic [ACC_WIDTH-1:0]  acc_out,
   output logic                  acc_valid,
   input  logic                  acc_ready
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2,
      S_OUT   = 2'd3
   } state_t;

   state_t state, state_nxt;

   logic [ADDR_WIDTH-1:0]        count;
   logic [ADDR_WIDTH-1:0]        addr;
   logic                         ce;
   logic                         rd_valid;
   logic signed [P_WIDTH-1:0]    prod_s;
   logic signed [ACC_WIDTH-1:0]  prod_ext;
   logic signed [ACC_WIDTH-1:0]  acc;
   logic signed [ACC_WIDTH-1:0]  acc_sum;
   logic signed [ACC_WIDTH-1:0]  out_val;
   logic [ACC_WIDTH-1:0]         out_reg;
   logic                         run_last;

   // Operands go to the multiplier straight from the RAM data.
   assign mul_a  = a_q;
   assign mul_b  = b_q;

   assign a_addr = addr;
   assign b_addr = addr;
   assign a_ce   = ce;
   assign b_ce   = ce;

   // A signed size cast sign-extends the product to the accumulator width.
   assign prod_s   = mul_p;
   assign prod_ext = ACC_WIDTH'(prod_s);
   assign acc_sum  = acc + prod_ext;

   // The final element lands during DRAIN, so the output register is loaded
   // from the same sum that updates acc.
`ifdef MAC_SEQ_RELU_EN
   assign out_val = acc_sum[ACC_WIDTH-1] ? '0 : acc_sum;
`else
   assign out_val = acc_sum;
`endif

   assign run_last  = (count == ADDR_WIDTH'(1));

   assign busy      = (state != S_IDLE);
   assign acc_valid = (state == S_OUT);
   assign acc_out   = out_reg;

   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (start) begin
               state_nxt = (len != '0) ? S_RUN : S_OUT;
            end
         end
         S_RUN: begin
            if (run_last) begin
               state_nxt = S_DRAIN;
            end
         end
         S_DRAIN: begin
            state_nxt = S_OUT;
         end
         S_OUT: begin
            if (acc_ready) begin
               state_nxt = S_IDLE;
            end
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   // Read data is valid one cycle after the read enable.
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         rd_valid <= 1'b0;
      end else begin
         rd_valid <= ce;
      end
   end

   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         count   <= '0;
         addr    <= '0;
         ce      <= 1'b0;
         acc     <= '0;
         out_reg <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  acc <= '0;
                  if (len != '0) begin
                     count <= len;
                     addr  <= '0;
                     ce    <= 1'b1;
                  end else begin
                     out_reg <= '0;
                  end
               end
            end
            S_RUN: begin
               if (rd_valid) begin
                  acc <= acc_sum;
               end
               count <= count - ADDR_WIDTH'(1);
               if (run_last) begin
                  ce <= 1'b0;
               end else begin
                  addr <= addr + ADDR_WIDTH'(1);
               end
            end
            S_DRAIN: begin
               acc     <= acc_sum;
               out_reg <= out_val;
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mac_dot_sequencer.sv
module tb_mac_dot_sequencer;

   logic        ap_clk;
   logic        ap_rst_n;
   logic        start;
   logic [9:0]  len;
   logic        busy;
   logic [9:0]  a_addr;
   logic        a_ce;
   logic [12:0] a_q;
   logic [9:0]  b_addr;
   logic        b_ce;
   logic [9:0]  b_q;
   logic [12:0] mul_a;
   logic [9:0]  mul_b;
   logic [22:0] mul_p;
   logic [31:0] acc_out;
   logic        acc_valid;
   logic        acc_ready;

   int checks   = 0;
   int failures = 0;
   int sb_err   = 0;

   logic [12:0]        amem [1024];
   logic signed [9:0]  bmem [1024];
   logic [9:0]         ce_addrs [$];

   mac_dot_sequencer dut (
      .ap_clk    (ap_clk),
      .ap_rst_n  (ap_rst_n),
      .start     (start),
      .len       (len),
      .busy      (busy),
      .a_addr    (a_addr),
      .a_ce      (a_ce),
      .a_q       (a_q),
      .b_addr    (b_addr),
      .b_ce      (b_ce),
      .b_q       (b_q),
      .mul_a     (mul_a),
      .mul_b     (mul_b),
      .mul_p     (mul_p),
      .acc_out   (acc_out),
      .acc_valid (acc_valid),
      .acc_ready (acc_ready)
   );

   initial ap_clk = 1'b0;
   always #5 ap_clk = ~ap_clk;

   // Multiplier: unsigned activation times signed weight.
   logic signed [23:0] prod_full;
   assign prod_full = $signed({1'b0, mul_a}) * $signed(mul_b);
   assign mul_p     = prod_full[22:0];

   // RAMs with one cycle of read latency.
   initial begin
      a_q = '0;
      b_q = '0;
   end
   always @(posedge ap_clk) begin
      if (a_ce) a_q <= amem[a_addr];
      if (b_ce) b_q <= bmem[b_addr];
   end

   always @(posedge ap_clk) begin
      if (ap_rst_n) begin
         if (a_ce === 1'b1) ce_addrs.push_back(a_addr);
         if (b_ce !== a_ce || b_addr !== a_addr) sb_err++;
      end
   end

   function automatic logic [31:0] model(input int n);
      longint s = 0;
      logic [31:0] r;
      for (int i = 0; i < n; i++) s += longint'(amem[i]) * longint'(bmem[i]);
      r = s[31:0];
`ifdef MAC_SEQ_RELU_EN
      if (r[31]) r = '0;
`endif
      return r;
   endfunction

   task automatic fill_random(input int n);
      for (int i = 0; i < n; i++) begin
         amem[i] = 13'($urandom);
         bmem[i] = 10'($urandom);
      end
   endtask

   // One dot product: start, wait, check result/latency/reads, optional hold,
   // then handshake and confirm return to IDLE.
   task automatic do_op(input int n, input int hold, input string tag);
      int cyc;
      int bad;
      logic [31:0] exp_v;
      logic [31:0] held;
      exp_v = model(n);
      @(negedge ap_clk);
      ce_addrs.delete();
      start = 1'b1;
      len   = 10'(n);
      @(negedge ap_clk);
      start = 1'b0;
      cyc   = 1;
      while (acc_valid !== 1'b1 && cyc < 300) begin
         @(negedge ap_clk);
         cyc++;
      end
      checks++;
      if (acc_valid !== 1'b1) begin
         failures++;
         $display("FAIL %s timeout acc_valid=%b required 1", tag, acc_valid);
      end
      checks++;
      if (cyc !== ((n == 0) ? 1 : n + 2)) begin
         failures++;
         $display("FAIL %s latency got %0d required %0d", tag, cyc, (n == 0) ? 1 : n + 2);
      end
      checks++;
      if (acc_out !== exp_v) begin
         failures++;
         $display("FAIL %s acc_out got %h required %h", tag, acc_out, exp_v);
      end
      checks++;
      if (ce_addrs.size() !== n) begin
         failures++;
         $display("FAIL %s ce_cycles got %0d required %0d", tag, ce_addrs.size(), n);
      end
      bad = 0;
      for (int i = 0; i < ce_addrs.size(); i++) if (ce_addrs[i] !== 10'(i)) bad++;
      checks++;
      if (bad !== 0) begin
         failures++;
         $display("FAIL %s addr_seq bad=%0d required 0", tag, bad);
      end
      held = acc_out;
      for (int h = 0; h < hold; h++) begin
         start = 1'b1;
         len   = 10'd3;
         @(negedge ap_clk);
         checks++;
         if (acc_out !== held || busy !== 1'b1 || acc_valid !== 1'b1) begin
            failures++;
            $display("FAIL %s hold%0d acc_out=%h busy=%b valid=%b required %h 1 1",
                     tag, h, acc_out, busy, acc_valid, held);
         end
      end
      acc_ready = 1'b1;
      @(negedge ap_clk);
      acc_ready = 1'b0;
      start     = 1'b0;
      checks++;
      if (acc_valid !== 1'b0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL %s post_hs valid=%b busy=%b required 0 0", tag, acc_valid, busy);
      end
      if (hold > 0) begin
         @(negedge ap_clk);
         checks++;
         if (busy !== 1'b0) begin
            failures++;
            $display("FAIL %s start_not_queued busy=%b required 0", tag, busy);
         end
      end
   endtask

   task automatic test_reset();
      ap_rst_n  = 1'b0;
      start     = 1'b0;
      len       = '0;
      acc_ready = 1'b0;
      repeat (2) @(negedge ap_clk);
      checks++;
      if (busy !== 0 || a_ce !== 0 || b_ce !== 0 || a_addr !== 0 || acc_valid !== 0 || acc_out !== 0) begin
         failures++;
         $display("FAIL reset busy=%b ce=%b addr=%h valid=%b out=%h required all 0",
                  busy, a_ce, a_addr, acc_valid, acc_out);
      end
      ap_rst_n = 1'b1;
      @(negedge ap_clk);
   endtask

   task automatic test_directed();
      amem[0] = 1; amem[1] = 2; amem[2] = 3; amem[3] = 4;
      bmem[0] = 5; bmem[1] = -1; bmem[2] = 2; bmem[3] = 3;
      do_op(4, 0, "len4");
      do_op(0, 0, "len0");
      for (int i = 0; i < 8; i++) begin
         amem[i] = 13'd8191;
         bmem[i] = -10'sd512;
      end
      do_op(8, 0, "signext");
      amem[0] = 3; amem[1] = 4;
      bmem[0] = -5; bmem[1] = 1;
      do_op(2, 0, "relu");
   endtask

   task automatic test_hold();
      fill_random(3);
      do_op(3, 5, "hold");
   endtask

   task automatic test_reset_midrun();
      fill_random(10);
      @(negedge ap_clk);
      start = 1'b1;
      len   = 10'd10;
      @(negedge ap_clk);
      start = 1'b0;
      repeat (2) @(negedge ap_clk);
      ap_rst_n = 1'b0;
      #1;
      checks++;
      if (busy !== 0 || a_ce !== 0 || a_addr !== 0 || acc_valid !== 0 || acc_out !== 0) begin
         failures++;
         $display("FAIL midrun_reset busy=%b ce=%b addr=%h valid=%b out=%h required all 0",
                  busy, a_ce, a_addr, acc_valid, acc_out);
      end
      @(negedge ap_clk);
      ap_rst_n = 1'b1;
      fill_random(2);
      do_op(2, 0, "after_reset");
   endtask

   task automatic test_random();
      for (int k = 0; k < 6; k++) begin
         int n;
         n = int'($urandom_range(0, 12));
         fill_random(n);
         do_op(n, int'($urandom_range(0, 2)), "random");
      end
   endtask

   task automatic test_back_to_back();
      fill_random(5);
      do_op(5, 0, "b2b_a");
      do_op(5, 0, "b2b_b");
      do_op(1, 0, "b2b_c");
      checks++;
      if (sb_err !== 0) begin
         failures++;
         $display("FAIL b_port_mirror errors=%0d required 0", sb_err);
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_hold();
      test_reset_midrun();
      test_random();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
